// File: rtl/tmds_serializer_n.sv
// tmds_serializer_n: multi-lane parallel-to-serial converter with a one-deep holding buffer and idle-symbol fill on underrun.
// Optional macro SER_DDR_EN: emit two bits per lane per x_clk for an external DDR output cell.
module tmds_serializer_n #(
  parameter int unsigned      WIDTH     = 10,
  parameter int unsigned      CHANNELS  = 3,
  parameter bit               MSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] IDLE_WORD = 10'b1101010100,
`ifdef SER_DDR_EN
  localparam int unsigned     LANE_BITS = 2
`else
  localparam int unsigned     LANE_BITS = 1
`endif
) (
  input  logic                          x_clk,
  input  logic                          rst,
  input  logic [CHANNELS*WIDTH-1:0]     word_data,
  input  logic                          word_valid,
  output logic                          word_ready,
  output logic [CHANNELS*LANE_BITS-1:0] ser_out,
  output logic                          word_strobe,
  output logic                          underrun,
  output logic                          underrun_sticky
);

  localparam int unsigned   N        = WIDTH / LANE_BITS;
  localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if (WIDTH < 2) begin : g_width_too_small
    $error("tmds_serializer_n: WIDTH must be at least 2");
  end
`ifdef SER_DDR_EN
  if ((WIDTH % 2) != 0) begin : g_width_odd
    $error("tmds_serializer_n: WIDTH must be even when SER_DDR_EN is defined");
  end
`endif

  typedef logic [CHANNELS-1:0][WIDTH-1:0] sym_t;

  logic [CW-1:0] cnt, cnt_nxt;
  logic          buf_full, buf_full_nxt;
  logic          armed, armed_nxt;
  sym_t          hold, hold_nxt;
  sym_t          shreg, shreg_nxt;
  logic          strobe_nxt, underrun_nxt, sticky_nxt;
  logic          reload, xfer;

  assign reload     = (cnt == CNT_LAST);
  assign word_ready = !buf_full || reload;
  assign xfer       = word_valid && word_ready;

  // Reload picks buffered word, then bypass, then idle; otherwise shift toward the output end.
  always_comb begin
    cnt_nxt      = reload ? '0 : cnt + CW'(1);
    buf_full_nxt = buf_full;
    hold_nxt     = hold;
    shreg_nxt    = shreg;
    armed_nxt    = armed || xfer;
    underrun_nxt = 1'b0;
    sticky_nxt   = underrun_sticky;
    strobe_nxt   = reload;
    if (reload) begin
      if (buf_full) begin
        shreg_nxt    = hold;
        buf_full_nxt = xfer;
        if (xfer) hold_nxt = word_data;
      end else if (xfer) begin
        shreg_nxt = word_data;
      end else begin
        shreg_nxt = {CHANNELS{IDLE_WORD}};
        if (armed) begin
          underrun_nxt = 1'b1;
          sticky_nxt   = 1'b1;
        end
      end
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        shreg_nxt[c] = MSB_FIRST ? (shreg[c] << LANE_BITS) : (shreg[c] >> LANE_BITS);
      end
      if (xfer) begin
        hold_nxt     = word_data;
        buf_full_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge x_clk) begin
    if (rst) begin
      cnt             <= CNT_LAST;
      buf_full        <= 1'b0;
      armed           <= 1'b0;
      hold            <= '0;
      shreg           <= '0;
      word_strobe     <= 1'b0;
      underrun        <= 1'b0;
      underrun_sticky <= 1'b0;
    end else begin
      cnt             <= cnt_nxt;
      buf_full        <= buf_full_nxt;
      armed           <= armed_nxt;
      hold            <= hold_nxt;
      shreg           <= shreg_nxt;
      word_strobe     <= strobe_nxt;
      underrun        <= underrun_nxt;
      underrun_sticky <= sticky_nxt;
    end
  end

  // Lane bit 0 carries the earlier bit of the stream.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar j = 0; j < LANE_BITS; j++) begin : g_lane
      assign ser_out[c*LANE_BITS + j] = MSB_FIRST ? shreg[c][WIDTH-1-j] : shreg[c][j];
    end
  end

endmodule
